// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter with a ready/valid request port.
// Produces eight packed BCD digits for the display controller and holds the last result.
module bin_to_bcd_converter #(
  parameter int IN_WIDTH = 27
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [IN_WIDTH-1:0] bin_in,
  input  logic                valid_in,
  output logic                ready_out,
  output logic [31:0]         val_out,
  output logic                valid_out,
  output logic                overflow_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [26:0] MAX_VAL   = 27'd99_999_999;
  localparam logic [4:0]  LAST_ITER = 5'(IN_WIDTH - 1);

  state_t              state_q;
  logic [31:0]         bcd_q;
  logic [IN_WIDTH-1:0] bin_q;
  logic [4:0]          cnt_q;
  logic                ovf_q;
  logic [31:0]         val_q;
  logic                valid_q;
  logic                overflow_q;

  logic [26:0]         bin_ext;
  logic [31:0]         bcd_adj;

  assign bin_ext = 27'(bin_in);

  // Add-3 correction on every digit before each shift.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                              : bcd_q[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      bcd_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      val_q      <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            bin_q   <= bin_in;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= (bin_ext > MAX_VAL);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // An out-of-range request spends one cycle here so its result lands two edges after accept.
          if (ovf_q) begin
            state_q <= DONE;
          end else begin
            bcd_q <= {bcd_adj[30:0], bin_q[IN_WIDTH-1]};
            bin_q <= bin_q << 1;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == LAST_ITER) state_q <= DONE;
          end
        end
        DONE: begin
          val_q      <= ovf_q ? 32'hEEEE_EEEE : bcd_q;
          overflow_q <= ovf_q;
          valid_q    <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_out    = (state_q == IDLE);
  assign val_out      = val_q;
  assign valid_out    = valid_q;
  assign overflow_out = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Bench for bin_to_bcd_converter: vector table, random values against a decimal-digit
// reference, held-valid streaming, reset aborts, and a narrow 4-bit instance.
module tb_bin_to_bcd_converter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [26:0] bin;
  logic        valid, ready, vout, ovf;
  logic [31:0] val;
  logic [3:0]  bin4;
  logic        valid4, ready4, vout4, ovf4;
  logic [31:0] val4;

  int checks = 0;
  int errors = 0;

  bin_to_bcd_converter #(.IN_WIDTH(27)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .bin_in(bin), .valid_in(valid),
    .ready_out(ready), .val_out(val), .valid_out(vout), .overflow_out(ovf)
  );

  bin_to_bcd_converter #(.IN_WIDTH(4)) dut4 (
    .clk_in(clk), .rst_n_in(rst_n), .bin_in(bin4), .valid_in(valid4),
    .ready_out(ready4), .val_out(val4), .valid_out(vout4), .overflow_out(ovf4)
  );

  typedef struct {
    logic [26:0] bin;
    logic [31:0] exp_val;
    logic        exp_ovf;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  // Decimal digits by division; out-of-range values map to the E pattern.
  function automatic logic [31:0] ref_bcd(input longint v);
    logic [31:0] r;
    longint p;
    r = '0;
    p = 1;
    if (v > 99_999_999) return 32'hEEEE_EEEE;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic convert_chk(input logic [26:0] v, input logic [31:0] exp_val,
                             input logic exp_ovf, input int exp_lat, input string name);
    int lat, rdy_low;
    bit seen;
    logic [31:0] res;
    logic o;
    chk({name, " ready_before"}, 32'(ready), 32'd1);
    bin   = v;
    valid = 1'b1;
    tick();
    valid   = 1'b0;
    bin     = 27'($urandom);
    lat     = 0;
    rdy_low = 0;
    seen    = 1'b0;
    res     = '0;
    o       = 1'b0;
    while (!seen && lat < 100) begin
      if (!ready) rdy_low++;
      tick();
      lat++;
      if (vout) begin
        seen = 1'b1;
        res  = val;
        o    = ovf;
      end
    end
    chk({name, " seen"}, 32'(seen), 32'd1);
    chk({name, " val"}, res, exp_val);
    chk({name, " ovf"}, 32'(o), 32'(exp_ovf));
    chk({name, " lat"}, 32'(lat), 32'(exp_lat));
    chk({name, " ready_low"}, 32'(rdy_low), 32'(exp_lat));
    tick();
    chk({name, " pulse_end"}, 32'(vout), 32'd0);
    chk({name, " hold"}, val, exp_val);
    $display("conv %s bin=%0d val=%h ovf=%0d lat=%0d", name, v, res, o, lat);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [26:0] q[$];
    logic [26:0] v, cur;
    logic        r;
    int          cyc, last_acc, lat, guard;

    vecs[0] = '{27'd12_345_678,  32'h1234_5678, 1'b0, 28};
    vecs[1] = '{27'd99_999_999,  32'h9999_9999, 1'b0, 28};
    vecs[2] = '{27'd100_000_000, 32'hEEEE_EEEE, 1'b1, 2};
    vecs[3] = '{27'd0,           32'h0000_0000, 1'b0, 28};
    vecs[4] = '{27'd9,           32'h0000_0009, 1'b0, 28};
    vecs[5] = '{27'd10,          32'h0000_0010, 1'b0, 28};
    vecs[6] = '{27'd80_808_080,  32'h8080_8080, 1'b0, 28};
    vecs[7] = '{27'h7FF_FFFF,    32'hEEEE_EEEE, 1'b1, 2};

    rst_n = 1'b0; valid = 1'b0; bin = '0; valid4 = 1'b0; bin4 = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("reset val", val, 32'h0);
    chk("reset valid", 32'(vout), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    chk("reset ready", 32'(ready), 32'd1);

    for (int i = 0; i < 8; i++)
      convert_chk(vecs[i].bin, vecs[i].exp_val, vecs[i].exp_ovf, vecs[i].exp_lat,
                  $sformatf("vec%0d", i));

    // Reset in the middle of a conversion, with an overflow result still held.
    bin = 27'd12_345_678; valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("midreset val", val, 32'h0);
    chk("midreset valid", 32'(vout), 32'd0);
    chk("midreset ovf", 32'(ovf), 32'd0);
    chk("midreset ready", 32'(ready), 32'd1);
    $display("midreset val=%h ovf=%0d ready=%0d", val, ovf, ready);

    for (int i = 0; i < 20; i++) begin
      v = (i % 5 == 4) ? 27'($urandom_range(134_217_727, 100_000_000))
                       : 27'($urandom_range(99_999_999, 0));
      convert_chk(v, ref_bcd(v), v > 27'd99_999_999, (v > 27'd99_999_999) ? 2 : 28,
                  $sformatf("rnd%0d", i));
    end

    // valid held high while bin changes every cycle.
    cyc = 0; last_acc = -1;
    valid = 1'b1;
    bin = 27'($urandom_range(99_999_999, 0));
    for (int i = 0; i < 100; i++) begin
      r   = ready;
      cur = bin;
      tick();
      cyc++;
      if (vout) begin
        if (q.size() == 0) chk("stream unexpected", 32'd1, 32'd0);
        else begin
          v = q.pop_front();
          chk("stream val", val, ref_bcd(v));
          $display("stream bin=%0d val=%h", v, val);
        end
      end
      if (r) begin
        q.push_back(cur);
        if (last_acc >= 0) chk("stream period", 32'(cyc - last_acc), 32'd29);
        last_acc = cyc;
      end
      bin = 27'($urandom_range(99_999_999, 0));
    end
    valid = 1'b0;
    guard = 0;
    while (q.size() > 0 && guard < 40) begin
      tick();
      guard++;
      if (vout) begin
        v = q.pop_front();
        chk("stream drain val", val, ref_bcd(v));
        $display("stream bin=%0d val=%h", v, val);
      end
    end
    chk("stream drained", 32'(q.size()), 32'd0);
    tick();

    // Reset lands on the 10th SHIFT edge of 5_000_000.
    bin = 27'd5_000_000; valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("abort val", val, 32'h0);
    chk("abort valid", 32'(vout), 32'd0);
    chk("abort ready", 32'(ready), 32'd1);
    $display("abort val=%h valid=%0d ready=%0d", val, vout, ready);
    convert_chk(27'd5_000_000, 32'h0500_0000, 1'b0, 28, "after_abort");

    // Narrow instance: every 4-bit value, result after IN_WIDTH+1 edges.
    for (int n = 0; n < 16; n++) begin
      bin4 = 4'(n); valid4 = 1'b1;
      tick();
      valid4 = 1'b0;
      lat = 0;
      while (!vout4 && lat < 20) begin
        tick();
        lat++;
      end
      chk($sformatf("w4 val %0d", n), val4, ref_bcd(n));
      chk($sformatf("w4 lat %0d", n), 32'(lat), 32'd5);
      $display("w4 bin=%0d val=%h lat=%0d", n, val4, lat);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
